// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchronizer, debounce filter,
// qualified rise/fall pulses and sticky pending/overflow flags feeding one irq.
module edge_detect_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_pend,
    output logic [WIDTH-1:0] ovf,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = a;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= a;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A channel flips only after DEBOUNCE consecutive samples disagreeing with level.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]  = '0;
            accept[i] = 1'b0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) accept[i] = 1'b1;
                else                     cnt_d[i]  = cnt_q[i] + CNT_ONE;
            end
        end
        level_d = level_q ^ accept;
        rise_d  = accept & level_d & en & rise_en;
        fall_d  = accept & ~level_d & en & fall_en;
        q       = rise_d | fall_d;
        // A new edge wins over clr so no event is lost; clr acknowledges the old one.
        pend_d  = q | (pend_q & ~clr);
        ovf_d   = (q & pend_q & ~clr) | (ovf_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign event_pend = pend_q;
    assign ovf        = ovf_q;
    assign irq        = |pend_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: hand vectors for the corner cases, then random
// stimulus compared against a history-based reference model.
module tb_edge_detect_multi;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int OW   = 5 * W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, en, rise_en, fall_en, clr;
    logic [W-1:0] level, rise, fall, event_pend, ovf;
    logic         irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst(rst), .a(a), .en(en), .rise_en(rise_en),
        .fall_en(fall_en), .clr(clr), .level(level), .rise(rise),
        .fall(fall), .event_pend(event_pend), .ovf(ovf), .irq(irq)
    );

    typedef struct {
        string        name;
        logic         rst;
        logic [W-1:0] a, en, re, fe, clr;
        int           cycles;
        logic         chk;
        logic [W-1:0] lv, ri, fa, pe, ov;
    } vec_t;

    vec_t vecs[$];

    // Reference model: level flips when the last DEB synchronized samples all disagree with it.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_level, m_rise, m_fall, m_pend, m_ovf;

    task automatic model_edge();
        logic [W-1:0] s, and_all, or_all, flip, nl, q;
        if (rst) begin
            m_pipe = {};
            m_hist = {};
            for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
            for (int i = 0; i < DEB; i++)  m_hist.push_back('0);
            m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_ovf = '0;
            return;
        end
        if (SYNC == 0) s = a;
        else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(a);
        end
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        and_all = '1;
        or_all  = '0;
        foreach (m_hist[k]) begin
            and_all &= m_hist[k];
            or_all  |= m_hist[k];
        end
        flip   = (and_all & ~m_level) | (~or_all & m_level);
        nl     = m_level ^ flip;
        m_rise = flip & nl & en & rise_en;
        m_fall = flip & ~nl & en & fall_en;
        q      = m_rise | m_fall;
        m_ovf  = (q & m_pend & ~clr) | (m_ovf & ~clr);
        m_pend = q | (m_pend & ~clr);
        m_level = nl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [OW-1:0] pack(logic [W-1:0] lv, ri, fa, pe, ov);
        return {lv, ri, fa, pe, ov, |pe};
    endfunction

    task automatic check(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got lvl/rise/fall/pend/ovf/irq=%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b",
                     name, got[OW-1-:W], got[4*W:3*W+1], got[3*W:2*W+1], got[2*W:W+1], got[W:1], got[0],
                     exp[OW-1-:W], exp[4*W:3*W+1], exp[3*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
        end
    endtask

    function automatic void add(string n, logic r, logic [W-1:0] a_, en_, re_, fe_, clr_,
                                int cyc, logic chk, logic [W-1:0] lv, ri, fa, pe, ov);
        vec_t v;
        v.name = n; v.rst = r; v.a = a_; v.en = en_; v.re = re_; v.fe = fe_; v.clr = clr_;
        v.cycles = cyc; v.chk = chk; v.lv = lv; v.ri = ri; v.fa = fa; v.pe = pe; v.ov = ov;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; a = '0; en = '0; rise_en = '0; fall_en = '0; clr = '0;

        //   name            rst a     en    re    fe    clr  cyc chk lv    ri    fa    pe    ov
        add("reset_hold",     1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("pre_latency",    0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 5, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("rise_edge6",     0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
        add("rise_1cycle",    0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        add("fall_wait",      0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 5, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("fall_ovf",       0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        add("clr_all",        0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("glitch3_in",     0, 4'h1, 4'hF, 4'hF, 4'hF, 4'h0, 3, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("glitch3_reject", 0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 8, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("pulse4_in",      0, 4'h1, 4'hF, 4'hF, 4'hF, 4'h0, 4, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("pulse4_wait",    0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("pulse4_rise",    0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
        add("pulse4_after",   0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        add("pulse4_fall",    0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 3, 1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1);
        add("clr_ch0",        0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("ch1_rise_mask",  0, 4'h2, 4'hF, 4'hD, 4'hF, 4'h0, 6, 1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        add("ch1_fall",       0, 4'h0, 4'hF, 4'hD, 4'hF, 4'h0, 6, 1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0);
        add("clr_ch1",        0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("ch2_rise",       0, 4'h4, 4'hF, 4'hF, 4'hF, 4'h0, 6, 1, 4'h4, 4'h4, 4'h0, 4'h4, 4'h0);
        add("ch2_fall_wait",  0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 5, 0, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0);
        add("ch2_clr_edge",   0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h4, 1, 1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0);
        add("ch2_ovf",        0, 4'h4, 4'hF, 4'hF, 4'hF, 4'h0, 6, 1, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4);
        add("ch2_clr",        0, 4'h4, 4'hF, 4'hF, 4'hF, 4'h4, 1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add("ch3_dis_rise",   0, 4'hC, 4'h7, 4'hF, 4'hF, 4'h0, 6, 1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0);
        add("ch3_dis_fall",   0, 4'h4, 4'h7, 4'hF, 4'hF, 4'h0, 6, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add("mid_count",      0, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 4, 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add("mid_reset",      1, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("post_rst_wait",  0, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 5, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add("post_rst_rise",  0, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h5, 4'h5, 4'h0, 4'h5, 4'h0);
        add("post_rst_after", 0, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 1, 1, 4'h5, 4'h0, 4'h0, 4'h5, 4'h0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; a = vecs[i].a; en = vecs[i].en;
            rise_en = vecs[i].re; fall_en = vecs[i].fe; clr = vecs[i].clr;
            repeat (vecs[i].cycles) cycle();
            if (vecs[i].chk)
                check(vecs[i].name, {level, rise, fall, event_pend, ovf, irq},
                      pack(vecs[i].lv, vecs[i].ri, vecs[i].fa, vecs[i].pe, vecs[i].ov));
        end

        // Random phase: restart DUT and model together, then compare every cycle.
        rst = 1'b1; a = '0; clr = '0; en = '1; rise_en = '1; fall_en = '1;
        repeat (2) cycle();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(7) == 0) a[b] = ~a[b];
            for (int b = 0; b < W; b++)
                clr[b] = ($urandom_range(15) == 0);
            if (c % 64 == 0) begin
                en      = W'($urandom) | W'($urandom);
                rise_en = W'($urandom) | W'($urandom);
                fall_en = W'($urandom) | W'($urandom);
            end
            rst = ($urandom_range(499) == 0);
            cycle();
            check($sformatf("random_c%0d", c), {level, rise, fall, event_pend, ovf, irq},
                  pack(m_level, m_rise, m_fall, m_pend, m_ovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
